// File: rtl/writeback_queue_pkg.sv
// Shared CPU types used by the register-file writeback path.
//   word_t    : 32-bit data word
//   regbits_t : 5-bit architectural register select
//   wb_req_t  : one writeback request {sel, dat}
package writeback_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } wb_req_t;

endpackage

// File: rtl/writeback_queue.sv
// Buffered writeback queue in front of the register file's single write port.
// Two producers (A: ALU results, B: long-latency results) push into a small
// dual-push FIFO; one entry retires per cycle onto WEN/wsel/wdat. A youngest-
// match lookup lets decode read values that are queued but not yet written.
//
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   a_valid/a_sel/a_dat    port A request, a_ready = accepted when valid
//   b_valid/b_sel/b_dat    port B request, b_ready = accepted when valid
//   wb_stall               suppress retire this cycle
//   WEN/wsel/wdat          register file write port
//   rsel1/rsel2            forwarding lookup selects
//   fwd1_hit/fwd1_dat      youngest queued match for rsel1 (dat 0 on miss)
//   fwd2_hit/fwd2_dat      youngest queued match for rsel2 (dat 0 on miss)
//   count/empty            occupancy
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     a_valid,
  input  regbits_t                 a_sel,
  input  word_t                    a_dat,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  regbits_t                 b_sel,
  input  word_t                    b_dat,
  output logic                     b_ready,
  input  logic                     wb_stall,
  output logic                     WEN,
  output regbits_t                 wsel,
  output word_t                    wdat,
  input  regbits_t                 rsel1,
  input  regbits_t                 rsel2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output word_t                    fwd1_dat,
  output word_t                    fwd2_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic  hit;
    word_t dat;
  } fwd_t;

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_pop;
  logic [CW-1:0]   w_slots;
  logic            w_need_a;
  logic            w_a_ready;
  logic            w_b_ready;
  logic            w_push_a;
  logic            w_push_b;
  logic [PW-1:0]   w_b_idx;
  fwd_t            w_fwd1;
  fwd_t            w_fwd2;

  // Walk occupied entries oldest to youngest so the last match wins.
  // The head is included even when it retires this cycle: the register
  // file has no internal bypass, so the value must still be forwarded.
  function automatic fwd_t lookup(input wb_req_t       mem [DEPTH],
                                  input logic [PW-1:0] head,
                                  input logic [CW-1:0] cnt,
                                  input regbits_t      rsel);
    fwd_t          res;
    logic [PW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (rsel != '0 && CW'(i) < cnt && mem[idx].sel == rsel) begin
        res.hit = 1'b1;
        res.dat = mem[idx].dat;
      end
    end
    return res;
  endfunction

  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && !wb_stall;
  // A retire this cycle frees its slot for a same-cycle push.
  assign w_slots  = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_need_a = a_valid && (a_sel != '0);

  // Ready never looks at b_valid, so no loop through the producers.
  assign w_a_ready = (w_slots >= CW'(1));
  assign w_b_ready = (b_sel == '0) || (w_slots >= (w_need_a ? CW'(2) : CW'(1)));

  // Register-0 requests are accepted but never stored.
  assign w_push_a = w_need_a && w_a_ready;
  assign w_push_b = b_valid && w_b_ready && (b_sel != '0);
  assign w_b_idx  = r_tail + PW'(w_push_a);

  assign w_fwd1 = lookup(r_mem, r_head, r_count, rsel1);
  assign w_fwd2 = lookup(r_mem, r_head, r_count, rsel2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push_a) + PW'(w_push_b);
      r_count <= r_count + CW'(w_push_a) + CW'(w_push_b) - CW'(w_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (w_push_a) r_mem[r_tail]  <= '{sel: a_sel, dat: a_dat};
    if (w_push_b) r_mem[w_b_idx] <= '{sel: b_sel, dat: b_dat};
  end

  assign a_ready  = w_a_ready;
  assign b_ready  = w_b_ready;
  assign WEN      = w_pop;
  assign wsel     = w_pop ? r_mem[r_head].sel : '0;
  assign wdat     = w_pop ? r_mem[r_head].dat : '0;
  assign fwd1_hit = w_fwd1.hit;
  assign fwd1_dat = w_fwd1.dat;
  assign fwd2_hit = w_fwd2.hit;
  assign fwd2_dat = w_fwd2.dat;
  assign count    = r_count;
  assign empty    = w_empty;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random
// traffic, checked against a queue-based reference model and a write scoreboard.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic     CLK = 1'b0;
  logic     RST;
  logic     a_valid, b_valid, wb_stall;
  regbits_t a_sel, b_sel, rsel1, rsel2;
  word_t    a_dat, b_dat;
  logic     a_ready, b_ready, WEN, fwd1_hit, fwd2_hit, empty;
  regbits_t wsel;
  word_t    wdat, fwd1_dat, fwd2_dat;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;

  wb_req_t mq[$];   // reference model: queued entries, oldest first
  wb_req_t sb[$];   // scoreboard: expected register file writes in order

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_sel(a_sel), .a_dat(a_dat), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_dat(b_dat), .b_ready(b_ready),
    .wb_stall(wb_stall), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_dat(fwd1_dat), .fwd2_dat(fwd2_dat),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed write must be the next expected one.
  always @(negedge CLK) begin
    if (!RST && WEN === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got write sel=%0d dat=%h expected no write", wsel, wdat);
      end else begin
        wb_req_t e;
        e = sb.pop_front();
        chk("wb_sel", 32'(wsel), 32'(e.sel));
        chk("wb_dat", wdat, e.dat);
      end
    end
  end

  function automatic logic [32:0] model_fwd(input regbits_t rs);
    logic [32:0] r;
    r = '0;
    if (rs != 0)
      foreach (mq[i]) if (mq[i].sel == rs) r = {1'b1, mq[i].dat};
    return r;
  endfunction

  // Compare the DUT against the model mid-cycle, then advance the model
  // to what the next rising edge should do.
  task automatic check_and_step();
    int          n, sl;
    bit          pop_m, need_a, ea, eb;
    logic [32:0] f1, f2;
    n      = mq.size();
    pop_m  = (n > 0) && !wb_stall;
    sl     = DEPTH - n + int'(pop_m);
    need_a = a_valid && (a_sel != 0);
    ea     = (sl >= 1);
    eb     = (b_sel == 0) || (sl >= (need_a ? 2 : 1));
    f1     = model_fwd(rsel1);
    f2     = model_fwd(rsel2);
    chk("count",    32'(count),    32'(n));
    chk("empty",    32'(empty),    32'(n == 0));
    chk("a_ready",  32'(a_ready),  32'(ea));
    chk("b_ready",  32'(b_ready),  32'(eb));
    chk("WEN",      32'(WEN),      32'(pop_m));
    if (!pop_m) begin
      chk("wsel_idle", 32'(wsel), 32'd0);
      chk("wdat_idle", wdat,      32'd0);
    end
    chk("fwd1_hit", 32'(fwd1_hit), 32'(f1[32]));
    chk("fwd1_dat", fwd1_dat,      f1[31:0]);
    chk("fwd2_hit", 32'(fwd2_hit), 32'(f2[32]));
    chk("fwd2_dat", fwd2_dat,      f2[31:0]);
    #1;
    if (pop_m) void'(mq.pop_front());
    if (need_a && ea) begin
      mq.push_back('{sel: a_sel, dat: a_dat});
      sb.push_back('{sel: a_sel, dat: a_dat});
    end
    if (b_valid && eb && b_sel != 0) begin
      mq.push_back('{sel: b_sel, dat: b_dat});
      sb.push_back('{sel: b_sel, dat: b_dat});
    end
  endtask

  // One clock cycle; called 1 time unit after a rising edge.
  task automatic cyc(input bit av, input int as, input word_t ad,
                     input bit bv, input int bs, input word_t bd,
                     input bit st, input int r1, input int r2);
    a_valid = av; a_sel = regbits_t'(as); a_dat = ad;
    b_valid = bv; b_sel = regbits_t'(bs); b_dat = bd;
    wb_stall = st; rsel1 = regbits_t'(r1); rsel2 = regbits_t'(r2);
    @(negedge CLK);
    check_and_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, st, 0, 0);
  endtask

  initial begin
    RST = 1'b1;
    a_valid = 0; a_sel = 0; a_dat = 0;
    b_valid = 0; b_sel = 0; b_dat = 0;
    wb_stall = 0; rsel1 = 0; rsel2 = 0;
    #1;
    chk("rst_WEN",   32'(WEN),   32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single A write, forwarded while queued.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0,            0, 0, 0, 0, 5, 0);
    idle(1, 0);

    // A and B to the same register: retire in order, forward the younger.
    cyc(1, 3, 32'd1, 1, 3, 32'd2, 1, 3, 0);
    cyc(0, 0, 0,     0, 0, 0,     1, 3, 3);
    idle(3, 0);

    // Fill under stall, then probe full behaviour.
    for (int i = 1; i <= 4; i++) cyc(1, i, 32'h100 + i, 0, 0, 0, 1, i, 2);
    cyc(1, 9, 32'h9,   1, 7, 32'h7, 1, 4, 1);
    cyc(0, 0, 0,       1, 0, 32'h5, 1, 0, 3);
    cyc(1, 10, 32'hA,  1, 11, 32'hB, 0, 10, 1);
    idle(6, 0);

    // Count 3 with both producers: two free slots.
    for (int i = 1; i <= 3; i++) cyc(1, i + 20, 32'h200 + i, 0, 0, 0, 1, 0, 0);
    cyc(1, 24, 32'h204, 1, 25, 32'h205, 0, 25, 24);
    cyc(1, 26, 32'h206, 1, 27, 32'h207, 0, 26, 27);
    idle(6, 0);

    // Register 0 requests are swallowed.
    cyc(1, 0, 32'h55, 1, 0, 32'h66, 0, 0, 0);
    cyc(1, 0, 32'h77, 1, 0, 32'h88, 1, 0, 0);
    idle(2, 0);

    // Asynchronous reset with three entries queued.
    for (int i = 1; i <= 3; i++) cyc(1, i + 12, 32'h300 + i, 0, 0, 0, 1, 0, 0);
    a_valid = 0; b_valid = 0; wb_stall = 0;
    @(negedge CLK);
    chk("pre_rst_WEN", 32'(WEN), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("async_WEN",   32'(WEN),   32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    mq.delete();
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(4, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle(8, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
